regfile_mp: RTL and testbench

// Parametrised multi-read-port integer register file for the RV32IM core, successor to the

---
 rtl/regfile_mp.sv | 120 ++++++++++++
 tb/tb_regfile_mp.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file with clear sequencer.
// Optional build macro REGFILE_BYPASS_EN enables write-to-read forwarding.
module regfile_mp #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    parameter  int NRD   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rsi,
    input  logic [NRD-1:0]    rs_en,
    input  logic [AW-1:0]     rdi,
    input  logic [XLEN-1:0]   rd,
    input  logic              write_enable,
    output logic [NRD*XLEN-1:0] rs,
    output logic              ready,
    output logic              wr_err
);

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [AW-1:0]   r_clr_idx;
    logic            r_ready;
    logic            r_wr_err;
    logic            w_clr_we;
    logic            w_wr_ok;
    logic            w_wr_drop;
    logic [XLEN-1:0] r_mem [NREGS];
    logic [XLEN-1:0] r_rs  [NRD];

    // Next state plus the per-edge write strobes; nothing happens on a reset edge.
    always_comb begin
        w_next_state = r_state;
        w_clr_we     = 1'b0;
        w_wr_ok      = 1'b0;
        w_wr_drop    = 1'b0;
        if (!rst) begin
            unique case (r_state)
                S_CLEAR: begin
                    w_clr_we  = 1'b1;
                    w_wr_drop = write_enable;
                    if (r_clr_idx == AW'(NREGS - 1))
                        w_next_state = S_READY;
                end
                S_READY: begin
                    w_wr_ok = write_enable && (rdi != '0);
                end
                default: ;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_CLEAR;
        else
            r_state <= w_next_state;
    end

    // Clear index, ready flag and dropped-write pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_idx <= AW'(1);
            r_ready   <= 1'b0;
            r_wr_err  <= 1'b0;
        end else begin
            if (w_clr_we)
                r_clr_idx <= r_clr_idx + AW'(1);
            r_ready  <= (w_next_state == S_READY);
            r_wr_err <= w_wr_drop;
        end
    end

    // Storage array: the sequencer zeroes entries, x0 is never written.
    always_ff @(posedge clk) begin
        if (w_clr_we)
            r_mem[r_clr_idx] <= '0;
        else if (w_wr_ok)
            r_mem[rdi] <= rd;
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0] w_rsi;
        logic          w_fwd;

        assign w_rsi = rsi[g*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        assign w_fwd = w_wr_ok && (rdi == w_rsi);
`else
        assign w_fwd = 1'b0;
`endif

        // Registered read port; holds its value while disabled.
        always_ff @(posedge clk) begin
            if (rst)
                r_rs[g] <= '0;
            else if (rs_en[g]) begin
                if (r_state == S_CLEAR || w_rsi == '0)
                    r_rs[g] <= '0;
                else if (w_fwd)
                    r_rs[g] <= rd;
                else
                    r_rs[g] <= r_mem[w_rsi];
            end
        end

        assign rs[g*XLEN +: XLEN] = r_rs[g];
    end

    assign ready  = r_ready;
    assign wr_err = r_wr_err;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and random checks of regfile_mp against a
// cycle-level behavioural model of the register file.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rsi;
    logic [NRD-1:0]      rs_en;
    logic [AW-1:0]       rdi;
    logic [XLEN-1:0]     rd;
    logic                write_enable;
    logic [NRD*XLEN-1:0] rs;
    logic                ready;
    logic                wr_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [XLEN-1:0] m_mem [NREGS];
    logic [XLEN-1:0] m_rs  [NRD];
    bit              m_ready;
    bit              m_err;
    int              m_cnt;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk          (clk),
        .rst          (rst),
        .rsi          (rsi),
        .rs_en        (rs_en),
        .rdi          (rdi),
        .rd           (rd),
        .write_enable (write_enable),
        .rs           (rs),
        .ready        (ready),
        .wr_err       (wr_err)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] port(input int i);
        return rs[i*XLEN +: XLEN];
    endfunction

    function automatic logic [AW-1:0] idx(input int i);
        return rsi[i*AW +: AW];
    endfunction

    task automatic idle();
        rst          = 1'b0;
        write_enable = 1'b0;
        rs_en        = '0;
        rsi          = '0;
        rdi          = '0;
        rd           = '0;
    endtask

    task automatic step();
        bit was_ready;
        @(posedge clk);
        if (rst) begin
            m_cnt   = 0;
            m_ready = 1'b0;
            m_err   = 1'b0;
            for (int i = 0; i < NRD; i++) m_rs[i] = '0;
        end else begin
            was_ready = m_ready;
            m_err = !was_ready && write_enable;
            for (int i = 0; i < NRD; i++) begin
                if (rs_en[i]) begin
                    if (!was_ready || idx(i) == 0)
                        m_rs[i] = '0;
                    else if (BYP && write_enable && rdi == idx(i))
                        m_rs[i] = rd;
                    else
                        m_rs[i] = m_mem[idx(i)];
                end
            end
            if (was_ready) begin
                if (write_enable && rdi != 0) m_mem[rdi] = rd;
            end else begin
                m_cnt++;
                m_mem[m_cnt] = '0;
                if (m_cnt == NREGS - 1) m_ready = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        vectors++;
        if (ready !== 1'b0 || wr_err !== 1'b0 || rs !== '0) begin
            miscompares++;
            $display("FAIL reset_state: ready=%b wr_err=%b rs=%h want 0/0/0",
                     ready, wr_err, rs);
        end
        rst = 1'b0;
        for (int k = 1; k <= NREGS - 1; k++) begin
            step();
            vectors++;
            if (ready !== (k == NREGS - 1)) begin
                miscompares++;
                $display("FAIL ready_edge%0d: got %b want %b", k, ready, k == NREGS - 1);
            end
        end
    endtask

    task automatic test_clear_reads();
        idle();
        rs_en = '1;
        for (int r = 1; r < NREGS; r++) begin
            rsi = {AW'((r % (NREGS - 1)) + 1), AW'(r)};
            step();
            for (int i = 0; i < NRD; i++) begin
                vectors++;
                if (port(i) !== '0) begin
                    miscompares++;
                    $display("FAIL cleared_x%0d_p%0d: got %h want 0", idx(i), i, port(i));
                end
            end
        end
    endtask

    task automatic test_write_read();
        idle();
        write_enable = 1'b1;
        rdi = 5;
        rd  = 32'hDEADBEEF;
        step();
        idle();
        rs_en = '1;
        rsi   = {AW'(5), AW'(5)};
        step();
        for (int i = 0; i < NRD; i++) begin
            vectors++;
            if (port(i) !== 32'hDEADBEEF) begin
                miscompares++;
                $display("FAIL wr_rd_x5_p%0d: got %h want deadbeef", i, port(i));
            end
        end
    endtask

    task automatic test_x0();
        idle();
        write_enable = 1'b1;
        rdi = 0;
        rd  = 32'hFFFFFFFF;
        step();
        vectors++;
        if (wr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL x0_wr_err: got %b want 0", wr_err);
        end
        idle();
        rs_en = '1;
        step();
        for (int i = 0; i < NRD; i++) begin
            vectors++;
            if (port(i) !== '0 || wr_err !== 1'b0) begin
                miscompares++;
                $display("FAIL x0_read_p%0d: got %h err %b want 0 err 0", i, port(i), wr_err);
            end
        end
    endtask

    task automatic test_same_cycle();
        logic [XLEN-1:0] exp_first;
        idle();
        write_enable = 1'b1;
        rdi = 7;
        rd  = 32'h1;
        step();
        rd    = 32'h12345678;
        rs_en = 2'b01;
        rsi   = {AW'(0), AW'(7)};
        step();
        exp_first = BYP ? 32'h12345678 : 32'h1;
        vectors++;
        if (port(0) !== exp_first) begin
            miscompares++;
            $display("FAIL same_edge_x7: got %h want %h", port(0), exp_first);
        end
        write_enable = 1'b0;
        step();
        vectors++;
        if (port(0) !== 32'h12345678) begin
            miscompares++;
            $display("FAIL next_read_x7: got %h want 12345678", port(0));
        end
    endtask

    task automatic test_hold();
        idle();
        rs_en = 2'b10;
        rsi   = {AW'(5), AW'(0)};
        step();
        rs_en = 2'b00;
        rsi   = {AW'(9), AW'(0)};
        write_enable = 1'b1;
        rdi = 9;
        rd  = 32'hAAAA5555;
        step();
        rsi = {AW'(5), AW'(0)};
        rdi = 5;
        rd  = 32'h0BADF00D;
        step();
        vectors++;
        if (port(1) !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL hold_p1: got %h want deadbeef", port(1));
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst          = ($urandom_range(0, 199) == 0);
            write_enable = $urandom_range(0, 1);
            rdi          = AW'($urandom_range(0, 9));
            rd           = $urandom;
            rs_en        = NRD'($urandom);
            for (int i = 0; i < NRD; i++)
                rsi[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? rdi : AW'($urandom_range(0, NREGS - 1));
            step();
            vectors++;
            if (ready !== m_ready || wr_err !== m_err) begin
                miscompares++;
                $display("FAIL rand%0d_ctrl: ready=%b err=%b want %b %b",
                         n, ready, wr_err, m_ready, m_err);
            end
            for (int i = 0; i < NRD; i++) begin
                vectors++;
                if (port(i) !== m_rs[i]) begin
                    miscompares++;
                    $display("FAIL rand%0d_p%0d: got %h want %h", n, i, port(i), m_rs[i]);
                end
            end
        end
    endtask

    task automatic test_clear_write();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        write_enable = 1'b1;
        rdi = 3;
        rd  = 32'hCAFEF00D;
        step();
        vectors++;
        if (wr_err !== 1'b1) begin
            miscompares++;
            $display("FAIL clr_wr_err_set: got %b want 1", wr_err);
        end
        write_enable = 1'b0;
        rs_en = '1;
        rsi   = {AW'(NREGS - 1), AW'(3)};
        step();
        vectors++;
        if (wr_err !== 1'b0 || port(0) !== '0 || port(1) !== '0) begin
            miscompares++;
            $display("FAIL clr_pulse_reads: err=%b p0=%h p1=%h want 0 0 0",
                     wr_err, port(0), port(1));
        end
        while (m_cnt < 10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        rs_en = '0;
        for (int k = 1; k <= NREGS - 1; k++) begin
            step();
            vectors++;
            if (ready !== (k == NREGS - 1)) begin
                miscompares++;
                $display("FAIL restart_edge%0d: got %b want %b", k, ready, k == NREGS - 1);
            end
        end
        rs_en = 2'b01;
        rsi   = {AW'(0), AW'(3)};
        step();
        vectors++;
        if (port(0) !== '0) begin
            miscompares++;
            $display("FAIL x3_after_drop: got %h want 0", port(0));
        end
    endtask

    initial begin
        for (int r = 0; r < NREGS; r++) m_mem[r] = '0;
        for (int i = 0; i < NRD; i++) m_rs[i] = '0;
        m_ready = 1'b0;
        m_err   = 1'b0;
        m_cnt   = 0;
        idle();
        @(negedge clk);
        test_reset();
        test_clear_reads();
        test_write_read();
        test_x0();
        test_same_cycle();
        test_hold();
        test_random();
        test_clear_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
